// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, 2-bit branch counter encoding and the
// branch predictor table entry layout.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Widest tag any legal table size needs (ENTRIES >= 4 -> index >= 2 bits).
    localparam int unsigned TAG_MAX_W = 28;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt2_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [29:0]          target;
        cnt2_e                counter;
    } bp_entry_t;

    // Tag is everything above the index and the byte offset, zero-extended
    // into the fixed-width tag field.
    function automatic logic [TAG_MAX_W-1:0] pc_tag(input word_t pc, input int unsigned idx_w);
        word_t shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[TAG_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic of a 2-bit saturating taken/not-taken counter.
module sat_counter2
    import cpu_types_pkg::*;
(
    input  cnt2_e cur,
    input  logic  taken,
    output cnt2_e next
);

    // Step toward the observed outcome, holding at either end.
    always_comb begin
        next = cur;
        unique case (cur)
            SNT: next = taken ? WNT : SNT;
            WNT: next = taken ? WT  : SNT;
            WT:  next = taken ? ST  : WNT;
            ST:  next = taken ? ST  : WT;
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// (MODE=1) or static not-taken prediction (MODE=0), plus saturating lookup
// and misprediction statistics.
module branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned MODE    = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             lookup_en,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             upd_en,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispred,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam bit          DYNAMIC = (MODE == 1);

    bp_entry_t table_q [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0] lk_idx;
    bp_entry_t        lk_entry;
    logic             lk_hit;

    // Update side
    logic [IDX_W-1:0] up_idx;
    bp_entry_t        up_entry;
    logic             up_hit;
    cnt2_e            sat_next;
    logic             upd_we;
    bp_entry_t        upd_entry_d;

    logic [CNT_W-1:0] lookup_cnt_q,  lookup_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // Target is word aligned; its byte offset never reaches the table.
    logic unused_tgt_lsbs;
    assign unused_tgt_lsbs = ^upd_target[1:0];

    assign lk_idx   = lookup_pc[IDX_W+1:2];
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == pc_tag(lookup_pc, IDX_W));

    assign up_idx   = upd_pc[IDX_W+1:2];
    assign up_entry = table_q[up_idx];
    assign up_hit   = up_entry.valid && (up_entry.tag == pc_tag(upd_pc, IDX_W));

    sat_counter2 u_sat (
        .cur   (up_entry.counter),
        .taken (upd_taken),
        .next  (sat_next)
    );

    // Zero-latency prediction straight from the registered table (no bypass).
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = lookup_pc + 32'd4;
        if (DYNAMIC && lk_hit && lk_entry.counter[1]) begin
            pred_taken  = 1'b1;
            pred_target = {lk_entry.target, 2'b00};
        end
    end

    // Decide whether and how the resolved branch rewrites its table entry.
    always_comb begin
        upd_we      = 1'b0;
        upd_entry_d = up_entry;
        if (DYNAMIC && upd_en) begin
            if (up_hit) begin
                upd_we              = 1'b1;
                upd_entry_d.counter = sat_next;
                if (upd_taken) begin
                    upd_entry_d.target = upd_target[31:2];
                end
            end else if (upd_taken) begin
                upd_we              = 1'b1;
                upd_entry_d.valid   = 1'b1;
                upd_entry_d.tag     = pc_tag(upd_pc, IDX_W);
                upd_entry_d.target  = upd_target[31:2];
                upd_entry_d.counter = WT;
            end
        end
    end

    // Flip-flop table: cleared by reset, one entry written per update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '0;
            end
        end else if (upd_we) begin
            table_q[up_idx] <= upd_entry_d;
        end
    end

    // Saturating statistics next-state.
    always_comb begin
        lookup_cnt_d  = lookup_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (lookup_en && (lookup_cnt_q != '1)) begin
            lookup_cnt_d = lookup_cnt_q + CNT_W'(1);
        end
        if (upd_en && upd_mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            lookup_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            lookup_cnt_q  <= lookup_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign lookup_cnt  = lookup_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Param ENTRIES, 16, number of direct-mapped table entries; power of two, 4..256.
REQ-002 Param MODE, 1, 0 = static not-taken, 1 = dynamic 2-bit saturating counters.
REQ-003 Param CNT_W, 16, width of statistics counters.
REQ-004 CLK  in  1  system clock, all state rising-edge.
REQ-005 nRST  in  1  asynchronous active-low reset.
REQ-006 lookup_en  in  1  fetch-stage lookup valid (fetch accepted this cycle).
REQ-007 lookup_pc  in  32  PC of instruction being fetched.
REQ-008 pred_taken  out  1  predicted taken for lookup_pc.
REQ-009 pred_target  out  32  predicted next PC.
REQ-010 upd_en  in  1  resolved branch update strobe from execute/memory stage.
REQ-011 upd_pc  in  32  PC of resolved branch.
REQ-012 upd_taken  in  1  actual branch outcome.
REQ-013 upd_target  in  32  actual taken target.
REQ-014 upd_mispred  in  1  pipeline flushed due to this branch.
REQ-015 lookup_cnt  out  CNT_W  count of lookup_en cycles.
REQ-016 mispred_cnt  out  CNT_W  count of mispredicted updates.

Function
REQ-017 Index SHALL be pc[IDX_W+1:2], IDX_W = log2(ENTRIES); tag SHALL be pc[31:IDX_W+2].
REQ-018 Each entry SHALL hold valid, tag, target[31:2], 2-bit counter.
REQ-019 Lookup SHALL be combinational, zero latency: hit = valid & tag match.
REQ-020 MODE 1: pred_taken = hit & counter[1]; pred_target = stored target when pred_taken, else lookup_pc + 4.
REQ-021 MODE 0: pred_taken = 0, pred_target = lookup_pc + 4, table never written.
REQ-022 Update (MODE 1) SHALL take effect on the rising edge following upd_en high.
REQ-023 Update hit, taken: counter +1 saturating at 3; target overwritten with upd_target.
REQ-024 Update hit, not taken: counter -1 saturating at 0; target unchanged; entry stays valid.
REQ-025 Update miss, taken: allocate/replace entry: valid=1, new tag, target, counter=2 (weakly taken).
REQ-026 Update miss, not taken: no table change.
REQ-027 Simultaneous lookup and update to same index SHALL return pre-update state (no bypass).
REQ-028 lookup_cnt SHALL increment on each cycle with lookup_en=1, saturating at all-ones.
REQ-029 mispred_cnt SHALL increment on each cycle with upd_en=1 & upd_mispred=1, saturating at all-ones; counters active in both modes.
REQ-030 upd_mispred without upd_en SHALL be ignored.

Reset
REQ-031 nRST low SHALL asynchronously clear all valid bits, counters to 0, targets/tags to 0, lookup_cnt and mispred_cnt to 0.
REQ-032 During/after reset pred_taken SHALL be 0 and pred_target SHALL equal lookup_pc + 4.
REQ-033 Reset asserted mid-update SHALL discard the update; first post-reset edge with upd_en applies normally.

Structure
REQ-034 word_t and the predictor entry struct (valid, tag, target, counter) SHALL live in cpu_types_pkg; counter encodings (SNT=0, WNT=1, WT=2, ST=3) as an enum there.
REQ-035 Saturating 2-bit counter next-state logic SHALL be a sub-module sat_counter2 (inputs cur, taken; output next).
REQ-036 Table SHALL be flip-flop array; no memory macro.

Verification
REQ-037 Reset, lookup_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044, both counters 0.
REQ-038 Update pc=0x40 taken target=0x100, then lookup 0x40 -> pred_taken=1, pred_target=0x0000_0100.
REQ-039 From REQ-038 state, two not-taken updates at 0x40 -> counter 0, lookup 0x40 predicts 0x44; three taken updates -> counter 3, fourth taken stays 3.
REQ-040 ENTRIES=16: allocate 0x40 taken, then taken update 0x440 (same index, new tag) -> lookup 0x40 misses (0x44), lookup 0x440 hits.
REQ-041 Same-cycle lookup and first taken update at 0x80 -> that cycle pred_taken=0; next cycle pred_taken=1.
REQ-042 MODE=0, 5 lookups, 3 upd_en with upd_mispred=1, 1 upd_mispred without upd_en -> lookup_cnt=5, mispred_cnt=3, pred_taken always 0; CNT_W=4 with 20 lookups -> lookup_cnt=15.
